// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter between two requesters that runs
// complete 16-bit SPI frames (WR, EXT[2:0], 0, REG[2:0], DATA[7:0], MSB first)
// and returns read data or a completion to the winning requester.
//
// state | meaning
// IDLE  | waiting for a request; req_ready shows the arbitration winner
// SETUP | cs high, first bit on mosi, sck low for CLK_DIV cycles
// SHIFT | 16 bits, sck high then low for CLK_DIV cycles each
// HOLD  | sck low, cs still high for CLK_DIV cycles
// DONE  | one-cycle rsp_valid pulse to the owner, RR pointer update
// GAP   | cs-low turnaround for CLK_DIV cycles before the next accept
module spi_master_arbiter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [5:0]  req_ext_addr,
    input  logic [5:0]  req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic [2:0]  spi_addr,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic        spi_miso_oe
);

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        hi_q, hi_d;
    logic [15:0] frame_q, frame_d;
    logic        wr_q, wr_d;
    logic [2:0]  ext_q, ext_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  rx_q, rx_d;
    logic        err_q, err_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        sck_q, sck_d;
    logic        cs_q, cs_d;
    logic [2:0]  addr_q, addr_d;
    logic        mosi_q, mosi_d;

    logic        gnt;
    logic        accept;
    logic        wr_sel;
    logic [2:0]  ext_sel;
    logic [2:0]  reg_sel;
    logic [7:0]  wdata_sel;

    // Round-robin winner: with both valid, the requester not granted last wins.
    always_comb begin
        gnt = 1'b0;
        if (req_valid == 2'b11) begin
            gnt = ~last_q;
        end else if (req_valid[1]) begin
            gnt = 1'b1;
        end
    end

    assign accept    = (state_q == IDLE) && (req_valid != 2'b00) && !rst;
    assign req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    assign wr_sel    = gnt ? req_wr[1]          : req_wr[0];
    assign ext_sel   = gnt ? req_ext_addr[5:3]  : req_ext_addr[2:0];
    assign reg_sel   = gnt ? req_reg_addr[5:3]  : req_reg_addr[2:0];
    assign wdata_sel = gnt ? req_wdata[15:8]    : req_wdata[7:0];

    // Next-state, frame shifting, miso capture and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        hi_d        = hi_q;
        frame_d     = frame_q;
        wr_d        = wr_q;
        ext_d       = ext_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rx_d        = rx_q;
        err_d       = err_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = DIV_M1;
                    owner_d = gnt;
                    wr_d    = wr_sel;
                    ext_d   = ext_sel;
                    frame_d = {wr_sel, ext_sel, 1'b0, reg_sel, wr_sel ? wdata_sel : 8'h00};
                    rx_d    = 8'h00;
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = SHIFT;
                    cnt_d   = DIV_M1;
                    hi_d    = 1'b1;
                    bit_d   = 4'd15;
                end
            end
            SHIFT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    cnt_d = DIV_M1;
                    if (hi_q) begin
                        // sck falling edge: present the next bit on mosi
                        hi_d = 1'b0;
                        if (bit_q != 4'd0) begin
                            frame_d = {frame_q[14:0], 1'b0};
                        end
                    end else if (bit_q == 4'd0) begin
                        state_d = HOLD;
                    end else begin
                        // sck rising edge: bits 7..0 of a read carry slave data
                        hi_d  = 1'b1;
                        bit_d = bit_q - 4'd1;
                        if (!wr_q && (bit_q <= 4'd8)) begin
                            rx_d  = {rx_q[6:0], spi_miso & spi_miso_oe};
                            err_d = err_q | ~spi_miso_oe;
                        end
                    end
                end
            end
            HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d     = DONE;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = wr_q ? 8'h00 : rx_q;
                    rsp_err_d   = !wr_q && err_q;
                    last_d      = owner_q;
                end
            end
            DONE: begin
                state_d = GAP;
                cnt_d   = DIV_M1;
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sck_d  = (state_d == SHIFT) && hi_d;
        cs_d   = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        addr_d = cs_d ? ext_d : 3'd0;
        mosi_d = cs_d ? frame_d[15] : 1'b0;
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            bit_q       <= 4'd0;
            hi_q        <= 1'b0;
            frame_q     <= 16'h0000;
            wr_q        <= 1'b0;
            ext_q       <= 3'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            rx_q        <= 8'h00;
            err_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            sck_q       <= 1'b0;
            cs_q        <= 1'b0;
            addr_q      <= 3'd0;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            hi_q        <= hi_d;
            frame_q     <= frame_d;
            wr_q        <= wr_d;
            ext_q       <= ext_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sck_q       <= sck_d;
            cs_q        <= cs_d;
            addr_q      <= addr_d;
            mosi_q      <= mosi_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign spi_sck   = sck_q;
    assign spi_cs    = cs_q;
    assign spi_addr  = addr_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Testbench for spi_master_arbiter: a CLK_DIV=2 instance with a slave model
// and scoreboard, plus a CLK_DIV=1 instance for back-to-back frame timing.
module tb_spi_master_arbiter;

    typedef struct {
        logic [1:0]  rv;
        logic [7:0]  rdata;
        logic        err;
        logic [15:0] frame;
        int          cs_len;
        logic [2:0]  addr;
        int          lat;
        int          rises;
    } rsp_t;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    // CLK_DIV=2 instance
    logic [1:0]  req_valid = 2'b00, req_wr = 2'b00;
    logic [5:0]  req_ext_addr = 6'd0, req_reg_addr = 6'd0;
    logic [15:0] req_wdata = 16'd0;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err, spi_sck, spi_cs, spi_mosi, spi_miso, spi_miso_oe;
    logic [2:0]  spi_addr;

    // CLK_DIV=1 instance
    logic [1:0]  req_valid1 = 2'b00, req_wr1 = 2'b00;
    logic [5:0]  req_ext_addr1 = 6'd0, req_reg_addr1 = 6'd0;
    logic [15:0] req_wdata1 = 16'd0;
    logic [1:0]  req_ready1, rsp_valid1;
    logic [7:0]  rsp_rdata1;
    logic        rsp_err1, spi_sck1, spi_cs1, spi_mosi1;
    logic [2:0]  spi_addr1;

    spi_master_arbiter #(.CLK_DIV(2)) u_dut (
        .sclk(sclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_ext_addr(req_ext_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_addr(spi_addr), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
    );

    spi_master_arbiter #(.CLK_DIV(1)) u_dut1 (
        .sclk(sclk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
        .req_ext_addr(req_ext_addr1), .req_reg_addr(req_reg_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .spi_sck(spi_sck1), .spi_cs(spi_cs1), .spi_addr(spi_addr1), .spi_mosi(spi_mosi1),
        .spi_miso(1'b0), .spi_miso_oe(1'b1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Slave model: presents data bit (15 - rises seen) during the low phase.
    logic [7:0] slv_data = 8'h00;
    int         err_bit  = -1;
    int         rise_cnt = 0;
    int         slv_idx;
    always_comb begin
        slv_idx     = 15 - rise_cnt;
        spi_miso    = 1'b0;
        spi_miso_oe = 1'b1;
        if (slv_idx >= 0 && slv_idx <= 7) begin
            spi_miso = slv_data[slv_idx[2:0]];
            if (slv_idx == err_bit) begin
                spi_miso    = 1'b1;
                spi_miso_oe = 1'b0;
            end
        end
    end

    int          cyc = 0;
    always @(posedge sclk) cyc++;

    // Monitor for the CLK_DIV=2 instance
    int          cs_len = 0, acc_cyc = 0, both_rdy = 0;
    logic        prev_sck = 1'b0, prev_cs = 1'b0;
    logic [15:0] cap_frame = 16'd0;
    logic [2:0]  cap_addr = 3'd0;
    rsp_t        mon_o;
    rsp_t        obs_q[$];
    rsp_t        exp_q[$];
    int          grant_q[$];
    always @(negedge sclk) begin
        if (rst) begin
            rise_cnt = 0;
            cs_len   = 0;
            prev_sck = 1'b0;
            prev_cs  = 1'b0;
        end else begin
            if (spi_cs && !prev_cs) begin
                rise_cnt  = 0;
                cs_len    = 0;
                cap_frame = 16'd0;
                cap_addr  = spi_addr;
            end
            if (spi_cs) cs_len++;
            if (spi_sck && !prev_sck) begin
                cap_frame = {cap_frame[14:0], spi_mosi};
                rise_cnt++;
            end
            if (req_ready == 2'b11) both_rdy++;
            if ((req_ready & req_valid) != 2'b00) begin
                grant_q.push_back(req_ready[1] ? 1 : 0);
                acc_cyc = cyc;
            end
            if (rsp_valid != 2'b00) begin
                mon_o.rv     = rsp_valid;
                mon_o.rdata  = rsp_rdata;
                mon_o.err    = rsp_err;
                mon_o.frame  = cap_frame;
                mon_o.cs_len = cs_len;
                mon_o.addr   = cap_addr;
                mon_o.lat    = cyc - acc_cyc;
                mon_o.rises  = rise_cnt;
                obs_q.push_back(mon_o);
            end
            prev_sck = spi_sck;
            prev_cs  = spi_cs;
        end
    end

    // Monitor for the CLK_DIV=1 instance
    int   cs1_len = 0, rise1 = 0, low1 = 0, frames1 = 0, rsp1_cnt = 0;
    logic prev_sck1 = 1'b0, prev_cs1 = 1'b0;
    int   cs1_q[$], rise1_q[$], gap1_q[$], acc1_q[$];
    always @(negedge sclk) begin
        if (rst) begin
            cs1_len   = 0;
            rise1     = 0;
            low1      = 0;
            prev_sck1 = 1'b0;
            prev_cs1  = 1'b0;
        end else begin
            if (spi_cs1 && !prev_cs1) begin
                if (frames1 > 0) gap1_q.push_back(low1);
                cs1_len = 0;
                rise1   = 0;
            end
            if (!spi_cs1 && prev_cs1) begin
                cs1_q.push_back(cs1_len);
                rise1_q.push_back(rise1);
                frames1++;
                low1 = 0;
            end
            if (spi_cs1) cs1_len++; else low1++;
            if (spi_sck1 && !prev_sck1) rise1++;
            if ((req_ready1 & req_valid1) != 2'b00) acc1_q.push_back(cyc);
            if (rsp_valid1 != 2'b00) rsp1_cnt++;
            prev_sck1 = spi_sck1;
            prev_cs1  = spi_cs1;
        end
    end

    function automatic rsp_t model(input int r, input bit wr, input logic [2:0] ext,
                                   input logic [2:0] rg, input logic [7:0] d,
                                   input logic [7:0] slv, input int eb);
        rsp_t e;
        e.rv     = (r == 1) ? 2'b10 : 2'b01;
        e.frame  = {wr, ext, 1'b0, rg, wr ? d : 8'h00};
        e.rdata  = wr ? 8'h00 : slv;
        e.err    = 1'b0;
        if (!wr && eb >= 0 && eb <= 7) begin
            e.rdata[eb[2:0]] = 1'b0;
            e.err            = 1'b1;
        end
        e.cs_len = 68;
        e.lat    = 69;
        e.rises  = 16;
        e.addr   = ext;
        return e;
    endfunction

    task automatic set_req(input int r, input bit wr, input logic [2:0] ext,
                           input logic [2:0] rg, input logic [7:0] d);
        if (r == 0) begin
            req_wr[0] = wr; req_ext_addr[2:0] = ext; req_reg_addr[2:0] = rg; req_wdata[7:0] = d;
            req_valid[0] = 1'b1;
        end else begin
            req_wr[1] = wr; req_ext_addr[5:3] = ext; req_reg_addr[5:3] = rg; req_wdata[15:8] = d;
            req_valid[1] = 1'b1;
        end
    endtask

    task automatic drive_req(input int r, input bit wr, input logic [2:0] ext,
                             input logic [2:0] rg, input logic [7:0] d);
        bit got = 1'b0;
        set_req(r, wr, ext, rg, d);
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (req_ready[r]) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge sclk);
        #1;
        req_valid = 2'b00;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: requester %0d never saw req_ready", r);
        end
    endtask

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sclk);
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout: no rsp_valid within 400 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        n_vec++;
        if ({spi_cs, spi_sck, spi_mosi, spi_addr, rsp_valid, rsp_rdata, rsp_err, req_ready} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs got cs=%b sck=%b mosi=%b addr=%0d rv=%b rd=%h err=%b rdy=%b exp all 0",
                     spi_cs, spi_sck, spi_mosi, spi_addr, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        n_vec++;
        if ({spi_cs1, spi_sck1, spi_mosi1, spi_addr1, rsp_valid1, rsp_rdata1, rsp_err1, req_ready1} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs_div1 got cs=%b sck=%b rv=%b exp all 0", spi_cs1, spi_sck1, rsp_valid1);
        end
        @(posedge sclk);
        #1 rst = 1'b0;
    endtask

    task automatic test_write();
        rsp_t o, e;
        bit   ok;
        slv_data = 8'h00;
        err_bit  = -1;
        exp_q.push_back(model(0, 1'b1, 3'd7, 3'd7, 8'hAA, 8'h00, -1));
        drive_req(0, 1'b1, 3'd7, 3'd7, 8'hAA);
        wait_obs(ok);
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.frame !== e.frame) begin n_err++; $display("FAIL wr_mosi_frame got %h exp %h", o.frame, e.frame); end
            n_vec++; if (o.cs_len !== e.cs_len) begin n_err++; $display("FAIL wr_cs_len got %0d exp %0d", o.cs_len, e.cs_len); end
            n_vec++; if (o.addr !== e.addr) begin n_err++; $display("FAIL wr_spi_addr got %0d exp %0d", o.addr, e.addr); end
            n_vec++; if (o.rv !== e.rv) begin n_err++; $display("FAIL wr_rsp_valid got %b exp %b", o.rv, e.rv); end
            n_vec++; if (o.lat !== e.lat) begin n_err++; $display("FAIL wr_rsp_cycle got %0d exp %0d", o.lat, e.lat); end
            n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL wr_rdata got %h exp %h", o.rdata, e.rdata); end
            n_vec++; if (o.rises !== e.rises) begin n_err++; $display("FAIL wr_sck_rises got %0d exp %0d", o.rises, e.rises); end
        end
    endtask

    task automatic test_read();
        rsp_t o, e;
        bit   ok;
        slv_data = 8'h5C;
        err_bit  = -1;
        exp_q.push_back(model(1, 1'b0, 3'd3, 3'd5, 8'hFF, 8'h5C, -1));
        drive_req(1, 1'b0, 3'd3, 3'd5, 8'hFF);
        wait_obs(ok);
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.frame !== e.frame) begin n_err++; $display("FAIL rd_mosi_frame got %h exp %h", o.frame, e.frame); end
            n_vec++; if (o.rv !== e.rv) begin n_err++; $display("FAIL rd_rsp_valid got %b exp %b", o.rv, e.rv); end
            n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL rd_rdata got %h exp %h", o.rdata, e.rdata); end
            n_vec++; if (o.err !== e.err) begin n_err++; $display("FAIL rd_err got %b exp %b", o.err, e.err); end
            n_vec++; if (o.addr !== e.addr) begin n_err++; $display("FAIL rd_spi_addr got %0d exp %0d", o.addr, e.addr); end
            repeat (4) @(negedge sclk);
            n_vec++;
            if ({rsp_valid, rsp_rdata} !== {2'b00, e.rdata}) begin
                n_err++;
                $display("FAIL rd_rdata_hold got rv=%b rd=%h exp rv=00 rd=%h", rsp_valid, rsp_rdata, e.rdata);
            end
        end
    endtask

    task automatic test_arb();
        rsp_t o, e;
        bit   ok;
        int   gbase, bbase;
        bit   got4 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;
        gbase    = grant_q.size();
        bbase    = both_rdy;
        slv_data = 8'h3C;
        err_bit  = -1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back(model(0, 1'b1, 3'd2, 3'd1, 8'h11, 8'h00, -1));
            else            exp_q.push_back(model(1, 1'b0, 3'd4, 3'd6, 8'h00, 8'h3C, -1));
        end
        set_req(0, 1'b1, 3'd2, 3'd1, 8'h11);
        set_req(1, 1'b0, 3'd4, 3'd6, 8'h00);
        for (int i = 0; i < 1000; i++) begin
            @(negedge sclk);
            if (grant_q.size() >= gbase + 4) begin
                got4 = 1'b1;
                break;
            end
        end
        @(posedge sclk);
        #1 req_valid = 2'b00;
        n_vec++;
        if (!got4) begin
            n_err++;
            $display("FAIL arb_grant_count got %0d exp 4", grant_q.size() - gbase);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (grant_q[gbase + k] !== (k % 2)) begin
                    n_err++;
                    $display("FAIL arb_grant_order[%0d] got %0d exp %0d", k, grant_q[gbase + k], k % 2);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            wait_obs(ok);
            if (ok) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                n_vec++; if (o.rv !== e.rv) begin n_err++; $display("FAIL arb_rsp_valid[%0d] got %b exp %b", k, o.rv, e.rv); end
                n_vec++; if (o.frame !== e.frame) begin n_err++; $display("FAIL arb_frame[%0d] got %h exp %h", k, o.frame, e.frame); end
                n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL arb_rdata[%0d] got %h exp %h", k, o.rdata, e.rdata); end
            end
        end
        n_vec++;
        if (both_rdy - bbase !== 0) begin
            n_err++;
            $display("FAIL arb_both_ready got %0d cycles exp 0", both_rdy - bbase);
        end
    endtask

    task automatic test_err_bit();
        rsp_t o, e;
        bit   ok;
        slv_data = 8'hA9;
        err_bit  = 3;
        exp_q.push_back(model(1, 1'b0, 3'd5, 3'd2, 8'h00, 8'hA9, 3));
        drive_req(1, 1'b0, 3'd5, 3'd2, 8'h00);
        wait_obs(ok);
        err_bit = -1;
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL oe_rdata got %h exp %h", o.rdata, e.rdata); end
            n_vec++; if (o.err !== e.err) begin n_err++; $display("FAIL oe_err got %b exp %b", o.err, e.err); end
            n_vec++; if (o.rv !== e.rv) begin n_err++; $display("FAIL oe_rsp_valid got %b exp %b", o.rv, e.rv); end
        end
    endtask

    task automatic test_reset_mid();
        rsp_t o, e;
        bit   ok;
        slv_data = 8'h00;
        err_bit  = -1;
        drive_req(0, 1'b1, 3'd6, 3'd3, 8'h5A);
        repeat (19) @(posedge sclk);
        @(negedge sclk);
        n_vec++;
        if (spi_cs !== 1'b1) begin n_err++; $display("FAIL mid_cs_before got %b exp 1", spi_cs); end
        rst = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
        n_vec++;
        if ({spi_cs, spi_sck, spi_mosi, spi_addr, rsp_valid, rsp_rdata, rsp_err, req_ready} !== 19'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs got cs=%b sck=%b mosi=%b addr=%0d rv=%b rd=%h err=%b rdy=%b exp all 0",
                     spi_cs, spi_sck, spi_mosi, spi_addr, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        @(posedge sclk);
        #1 rst = 1'b0;
        repeat (150) @(negedge sclk);
        n_vec++;
        if (obs_q.size() !== 0) begin n_err++; $display("FAIL mid_no_rsp got %0d responses exp 0", obs_q.size()); end
        slv_data = 8'h66;
        exp_q.push_back(model(1, 1'b0, 3'd2, 3'd4, 8'h00, 8'h66, -1));
        drive_req(1, 1'b0, 3'd2, 3'd4, 8'h00);
        wait_obs(ok);
        if (ok) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_vec++; if (o.rv !== e.rv) begin n_err++; $display("FAIL post_rst_rsp_valid got %b exp %b", o.rv, e.rv); end
            n_vec++; if (o.rdata !== e.rdata) begin n_err++; $display("FAIL post_rst_rdata got %h exp %h", o.rdata, e.rdata); end
            n_vec++; if (o.frame !== e.frame) begin n_err++; $display("FAIL post_rst_frame got %h exp %h", o.frame, e.frame); end
            n_vec++; if (o.lat !== e.lat) begin n_err++; $display("FAIL post_rst_rsp_cycle got %0d exp %0d", o.lat, e.lat); end
        end
    endtask

    task automatic test_back_to_back();
        int  cbase, abase, gbase, rbase;
        bit  got = 1'b0;
        cbase = cs1_q.size();
        abase = acc1_q.size();
        gbase = gap1_q.size();
        rbase = rsp1_cnt;
        req_wr1       = 2'b01;
        req_ext_addr1 = 6'd1;
        req_reg_addr1 = 6'd2;
        req_wdata1    = 16'h00C3;
        req_valid1    = 2'b01;
        for (int i = 0; i < 300; i++) begin
            @(negedge sclk);
            if (acc1_q.size() >= abase + 2) begin got = 1'b1; break; end
        end
        @(posedge sclk);
        #1 req_valid1 = 2'b00;
        for (int i = 0; i < 200; i++) begin
            @(negedge sclk);
            if (rsp1_cnt - rbase >= 2) break;
        end
        n_vec++;
        if (!got || cs1_q.size() < cbase + 2 || gap1_q.size() < gbase + 1) begin
            n_err++;
            $display("FAIL b2b_frames got accepts=%0d frames=%0d exp 2", acc1_q.size() - abase, cs1_q.size() - cbase);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (cs1_q[cbase + k] !== 34) begin n_err++; $display("FAIL b2b_cs_len[%0d] got %0d exp 34", k, cs1_q[cbase + k]); end
                n_vec++;
                if (rise1_q[cbase + k] !== 16) begin n_err++; $display("FAIL b2b_sck_rises[%0d] got %0d exp 16", k, rise1_q[cbase + k]); end
            end
            n_vec++;
            if (!(acc1_q[abase + 1] - acc1_q[abase] >= 37)) begin
                n_err++;
                $display("FAIL b2b_accept_spacing got %0d exp >=37", acc1_q[abase + 1] - acc1_q[abase]);
            end
            n_vec++;
            if (!(gap1_q[gbase] >= 1)) begin n_err++; $display("FAIL b2b_cs_gap got %0d exp >=1", gap1_q[gbase]); end
            n_vec++;
            if (rsp1_cnt - rbase !== 2) begin n_err++; $display("FAIL b2b_rsp_count got %0d exp 2", rsp1_cnt - rbase); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_arb();
        test_err_bit();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
